bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/ser_pkg.sv | 16 +
 rtl/ser_hold_reg.sv | 33 +++
 rtl/bit_serializer.sv | 98 +++++++++
 tb/tb_bit_serializer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// Shared types and defaults for the bit serializer.
package ser_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

   localparam logic SER_IDLE_BIT_DEFAULT = 1'b0;

   // Counter width for a word of data_w bits; never narrower than one bit.
   function automatic int ser_cnt_w(input int data_w);
      return (data_w > 1) ? $clog2(data_w) : 1;
   endfunction

endpackage

// File: rtl/ser_hold_reg.sv
// One-word holding register with a full flag.
// A load takes priority over a take on the same edge.
module ser_hold_reg #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_load,
   input  logic              i_take,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_full,
   output logic [DATA_W-1:0] o_data
);

   logic              r_full;
   logic [DATA_W-1:0] r_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_full <= 1'b0;
         r_data <= '0;
      end else if (i_load) begin
         r_full <= 1'b1;
         r_data <= i_data;
      end else if (i_take) begin
         r_full <= 1'b0;
      end
   end

   assign o_full = r_full;
   assign o_data = r_data;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter: IDLE/SHIFT FSM with a down-counting bit counter.
// Define SER_HOLD_EN to add a one-word holding register for gapless streaming.
//
//   state | meaning
//   IDLE  | no word shifting; ser_out = IDLE_BIT, ready for a word
//   SHIFT | driving one data bit per cycle; counter==0 is the last bit
module bit_serializer
   import ser_pkg::*;
#(
   parameter int   DATA_W    = 8,
   parameter bit   MSB_FIRST = 1'b1,
   parameter logic IDLE_BIT  = SER_IDLE_BIT_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              ser_out,
   output logic              ser_active,
   output logic              byte_done
);

   localparam int               CNT_W    = ser_cnt_w(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W - 1);

   ser_state_t        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_shift;

   logic              w_last;
   logic              w_accept;
   logic              w_in_ready;
   logic              w_load;
   logic [DATA_W-1:0] w_load_data;
   logic [DATA_W-1:0] w_shift_next;

   assign w_last   = (r_state == SHIFT) && (r_cnt == '0);
   assign w_accept = in_valid && w_in_ready;

`ifdef SER_HOLD_EN
   logic              w_hold_full;
   logic              w_hold_load;
   logic              w_hold_take;
   logic [DATA_W-1:0] w_hold_data;

   // Mid-word accepts park in hold; a last-bit accept with hold empty bypasses it.
   assign w_in_ready  = !w_hold_full;
   assign w_hold_take = w_last && w_hold_full;
   assign w_hold_load = w_accept && (r_state == SHIFT) && !w_last;
   assign w_load      = (w_accept && !w_hold_load) || w_hold_take;
   assign w_load_data = w_hold_full ? w_hold_data : in_data;

   ser_hold_reg #(
      .DATA_W (DATA_W)
   ) u_hold (
      .clk    (clk),
      .reset  (reset),
      .i_load (w_hold_load),
      .i_take (w_hold_take),
      .i_data (in_data),
      .o_full (w_hold_full),
      .o_data (w_hold_data)
   );
`else
   assign w_in_ready  = (r_state == IDLE) || w_last;
   assign w_load      = w_accept;
   assign w_load_data = in_data;
`endif

   assign w_shift_next = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_shift <= '0;
      end else if (w_load) begin
         r_state <= SHIFT;
         r_cnt   <= CNT_LOAD;
         r_shift <= w_load_data;
      end else if (r_state == SHIFT) begin
         if (w_last) begin
            r_state <= IDLE;
         end else begin
            r_cnt   <= r_cnt - CNT_W'(1);
            r_shift <= w_shift_next;
         end
      end
   end

   assign in_ready   = w_in_ready;
   assign ser_active = (r_state == SHIFT);
   assign byte_done  = w_last;
   assign ser_out    = (r_state == SHIFT) ?
                       (MSB_FIRST ? r_shift[DATA_W-1] : r_shift[0]) : IDLE_BIT;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: stimulus pushes expected bits, monitors pop them.
// Scenarios adapt to whether SER_HOLD_EN is defined.
module tb_bit_serializer;
   import ser_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] in_data,  in_data_l;
   logic       in_valid, in_valid_l;
   logic       in_ready, ser_out, ser_active, byte_done;
   logic       in_ready_l, ser_out_l, ser_active_l, byte_done_l;

   int n_checks = 0;
   int n_fail   = 0;
   logic mon_en = 1'b0;

   // Each entry: {expected ser_out, expected byte_done}
   logic [1:0] q_msb[$];
   logic [1:0] q_lsb[$];

   bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .ser_out    (ser_out),
      .ser_active (ser_active),
      .byte_done  (byte_done)
   );

   bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data_l),
      .in_valid   (in_valid_l),
      .in_ready   (in_ready_l),
      .ser_out    (ser_out_l),
      .ser_active (ser_active_l),
      .byte_done  (byte_done_l)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_msb(input logic [7:0] d);
      for (int i = 7; i >= 0; i--) q_msb.push_back({d[i], (i == 0) ? 1'b1 : 1'b0});
   endtask

   task automatic push_lsb(input logic [7:0] d);
      for (int i = 0; i < 8; i++) q_lsb.push_back({d[i], (i == 7) ? 1'b1 : 1'b0});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (ser_active) begin
            if (q_msb.size() == 0) begin
               check("msb_unexpected_bit", ser_active, 0);
            end else begin
               logic [1:0] e;
               e = q_msb.pop_front();
               check("msb_ser_out", ser_out, e[1]);
               check("msb_byte_done", byte_done, e[0]);
            end
         end else begin
            check("msb_idle_out", ser_out, 0);
            check("msb_idle_done", byte_done, 0);
            if (q_msb.size() != 0) check("msb_gap", ser_active, 1);
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         if (ser_active_l) begin
            if (q_lsb.size() == 0) begin
               check("lsb_unexpected_bit", ser_active_l, 0);
            end else begin
               logic [1:0] e;
               e = q_lsb.pop_front();
               check("lsb_ser_out", ser_out_l, e[1]);
               check("lsb_byte_done", byte_done_l, e[0]);
            end
         end else begin
            check("lsb_idle_out", ser_out_l, 0);
            if (q_lsb.size() != 0) check("lsb_gap", ser_active_l, 1);
         end
      end
   end

   initial begin
      reset      = 1'b1;
      in_valid   = 1'b0;
      in_data    = 8'h00;
      in_valid_l = 1'b0;
      in_data_l  = 8'h00;
      repeat (3) tick();
      reset = 1'b0;
      check("rst_in_ready", in_ready, 1);
      check("rst_ser_active", ser_active, 0);
      check("rst_ser_out", ser_out, 0);
      check("rst_byte_done", byte_done, 0);
      mon_en = 1'b1;
      tick();

      // Single word B4 on both bit orders.
      in_valid = 1'b1;  in_data = 8'hB4;
      in_valid_l = 1'b1; in_data_l = 8'hB4;
      check("s1_ready", in_ready, 1);
      check("s1_ready_lsb", in_ready_l, 1);
      tick();
      push_msb(8'hB4); push_lsb(8'hB4);
      in_valid = 1'b0; in_valid_l = 1'b0;
      check("s1_active_c1", ser_active, 1);
      repeat (7) tick();
      check("s1_done_c8", byte_done, 1);
      check("s1_done_c8_lsb", byte_done_l, 1);
      tick();
      check("s1_idle_active_c9", ser_active, 0);
      check("s1_idle_out_c9", ser_out, 0);
      check("s1_q_empty", q_msb.size(), 0);
      check("s1_q_empty_lsb", q_lsb.size(), 0);
      tick();

`ifndef SER_HOLD_EN
      // Back-to-back FF then 00 with in_valid held.
      in_valid = 1'b1; in_data = 8'hFF;
      check("b2b_ready_c0", in_ready, 1);
      tick();
      push_msb(8'hFF);
      in_data = 8'h00;
      for (int c = 1; c < 8; c++) begin
         check("b2b_ready_low", in_ready, 0);
         tick();
      end
      check("b2b_ready_c8", in_ready, 1);
      check("b2b_done_c8", byte_done, 1);
      tick();
      push_msb(8'h00);
      in_valid = 1'b0;
      check("b2b_active_c9", ser_active, 1);
      repeat (7) tick();
      check("b2b_done_c16", byte_done, 1);
      tick();
      check("b2b_idle_c17", ser_active, 0);
      tick();

      // Word offered mid-word while not ready is dropped.
      in_valid = 1'b1; in_data = 8'h3C;
      tick();
      push_msb(8'h3C);
      in_valid = 1'b0;
      repeat (2) tick();
      in_valid = 1'b1; in_data = 8'hC3;
      check("drop_ready_low", in_ready, 0);
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      check("drop_idle_c9", ser_active, 0);
      check("drop_q_empty", q_msb.size(), 0);
      tick();
`else
      // Hold register: A, B, C offered continuously.
      in_valid = 1'b1; in_data = 8'h0F;
      check("hold_ready_c0", in_ready, 1);
      tick();
      push_msb(8'h0F);
      in_data = 8'hF0;
      check("hold_ready_c1", in_ready, 1);
      tick();
      push_msb(8'hF0);
      in_data = 8'h55;
      for (int c = 2; c < 9; c++) begin
         check("hold_ready_low", in_ready, 0);
         tick();
      end
      check("hold_ready_c9", in_ready, 1);
      tick();
      push_msb(8'h55);
      in_valid = 1'b0;
      repeat (14) tick();
      check("hold_done_c24", byte_done, 1);
      tick();
      check("hold_idle_c25", ser_active, 0);
      check("hold_q_empty", q_msb.size(), 0);
      tick();
`endif

      // Reset during bit 4 of AA discards the rest of the word.
      in_valid = 1'b1; in_data = 8'hAA;
      tick();
      push_msb(8'hAA);
      in_valid = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      q_msb.delete();
      reset = 1'b0;
      check("rst_mid_active", ser_active, 0);
      check("rst_mid_out", ser_out, 0);
      check("rst_mid_ready", in_ready, 1);
      for (int c = 0; c < 10; c++) begin
         check("rst_mid_no_done", byte_done, 0);
         check("rst_mid_stay_idle", ser_active, 0);
         tick();
      end

      check("final_q_msb", q_msb.size(), 0);
      check("final_q_lsb", q_lsb.size(), 0);
      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
